// File: rtl/alu_seq.sv
// Multi-word ALU sequencer: drives an N-bit ALU one word per cycle (LSW first) for M*N-bit ADD/SUB/AND/OR.
// Optional signed-overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_seq #(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int AC_N = 4,
  parameter logic [AC_N-1:0] AC_AN  = AC_N'(0),
  parameter logic [AC_N-1:0] AC_OR  = AC_N'(1),
  parameter logic [AC_N-1:0] AC_AD  = AC_N'(2),
  parameter logic [AC_N-1:0] AC_ADX = AC_N'(3),
  parameter logic [AC_N-1:0] AC_SB  = AC_N'(4),
  parameter logic [AC_N-1:0] AC_SBX = AC_N'(5)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [M*N-1:0]  opnd_a,
  input  logic [M*N-1:0]  opnd_b,
  output logic            ready,
  output logic            done,
  output logic [M*N-1:0]  result,
  output logic            carry,
  output logic            zero,
`ifdef ALU_SEQ_OVF_EN
  output logic            ovf,
`endif
  output logic [AC_N-1:0] alu_cs,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_cout
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3} op_e;

  state_e          state, state_nxt;
  op_e             op_q;
  logic [M*N-1:0]  a_q, b_q;
  logic [M*N-1:0]  result_nxt;
  logic [IW-1:0]   idx;
  logic            chain_q;
  logic            last_word;
  logic            arith;

`ifdef ALU_SEQ_OVF_EN
  function automatic logic ovf_calc(input op_e o, input logic a_msb, input logic b_msb,
                                    input logic r_msb);
    case (o)
      OP_ADD:  return (a_msb == b_msb) && (r_msb != a_msb);
      OP_SUB:  return (a_msb != b_msb) && (r_msb != a_msb);
      default: return 1'b0;
    endcase
  endfunction
`endif

  assign last_word = (idx == LAST_IDX);
  assign arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ALU borrow is an inverted carry, so SUB feeds ~borrow back as carry-in.
  always_comb begin
    state_nxt = state;
    alu_cs    = AC_AN;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        alu_a = a_q[idx*N +: N];
        alu_b = b_q[idx*N +: N];
        case (op_q)
          OP_ADD: begin
            if (idx == '0) alu_cs = AC_ADX;
            else begin
              alu_cs  = AC_AD;
              alu_cin = chain_q;
            end
          end
          OP_SUB: begin
            if (idx == '0) alu_cs = AC_SBX;
            else begin
              alu_cs  = AC_SB;
              alu_cin = ~chain_q;
            end
          end
          OP_AND:  alu_cs = AC_AN;
          default: alu_cs = AC_OR;
        endcase
        if (last_word) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    result_nxt                = result;
    result_nxt[idx*N +: N]    = alu_s;
  end

  // Accept stage: operands are only latched, never reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op_q <= op_e'(op);
      a_q  <= opnd_a;
      b_q  <= opnd_b;
    end
  end

  // Run stage: one word captured per cycle; flags settle on the MSW.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      chain_q <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            chain_q <= 1'b0;
          end
        end
        S_RUN: begin
          result  <= result_nxt;
          chain_q <= alu_cout;
          idx     <= idx + IW'(1);
          if (last_word) begin
            carry <= arith & alu_cout;
            zero  <= ~|result_nxt;
`ifdef ALU_SEQ_OVF_EN
            ovf   <= ovf_calc(op_q, a_q[M*N-1], b_q[M*N-1], alu_s[N-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (M=2, N=8) with a behavioural N-bit ALU.
// Define ALU_SEQ_OVF_EN to also exercise the overflow output.
module tb_alu_seq;
  localparam int N = 8;
  localparam int M = 2;
  localparam int AC_N = 4;
  localparam logic [AC_N-1:0] C_AN = 4'd0, C_OR = 4'd1, C_AD = 4'd2,
                              C_ADX = 4'd3, C_SB = 4'd4, C_SBX = 4'd5;

  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] op;
  logic [M*N-1:0] opnd_a, opnd_b, result;
  logic ready, done, carry, zero;
  logic [AC_N-1:0] alu_cs;
  logic [N-1:0] alu_a, alu_b, alu_s;
  logic alu_cin, alu_cout;
`ifdef ALU_SEQ_OVF_EN
  logic ovf;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(N), .M(M), .AC_N(AC_N), .AC_AN(C_AN), .AC_OR(C_OR), .AC_AD(C_AD),
            .AC_ADX(C_ADX), .AC_SB(C_SB), .AC_SBX(C_SBX)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .ready(ready), .done(done), .result(result), .carry(carry), .zero(zero),
`ifdef ALU_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .alu_cs(alu_cs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_cout(alu_cout)
  );

  // Behavioural ALU: SB/SBX report borrow (inverted carry); ADX/SBX ignore carry-in.
  always_comb begin
    logic [N:0] t;
    t = '0;
    alu_s = '0;
    alu_cout = 1'b0;
    case (alu_cs)
      C_AN:  alu_s = alu_a & alu_b;
      C_OR:  alu_s = alu_a | alu_b;
      C_AD:  begin t = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin}; alu_s = t[N-1:0]; alu_cout = t[N]; end
      C_ADX: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_s = t[N-1:0]; alu_cout = t[N]; end
      C_SB:  begin t = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, alu_cin}; alu_s = t[N-1:0]; alu_cout = ~t[N]; end
      C_SBX: begin t = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1}; alu_s = t[N-1:0]; alu_cout = ~t[N]; end
      default: ;
    endcase
  end

  // Accepts one operation and waits (bounded) for done; lat counts edges from the accept edge.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    @(negedge clk);
    op = o; opnd_a = a; opnd_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opnd_a = 16'h5A5A; opnd_b = 16'hA5A5;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; opnd_a = '0; opnd_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({result, carry, zero} !== 18'h0) begin bad++; $display("FAIL reset_flags got=%h/%b/%b exp=0000/0/0", result, carry, zero); end
    total++; if ({alu_cs, alu_a, alu_b, alu_cin} !== {C_AN, 17'h0}) begin bad++; $display("FAIL reset_alu got=%h/%h/%h/%b exp=0/00/00/0", alu_cs, alu_a, alu_b, alu_cin); end
`ifdef ALU_SEQ_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_add_trace();
    @(negedge clk);
    op = 2'd0; opnd_a = 16'h00FF; opnd_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if ({alu_cs, alu_cin, alu_a, alu_b} !== {C_ADX, 1'b0, 8'hFF, 8'h01}) begin bad++; $display("FAIL add_w0 got cs=%h cin=%b a=%h b=%h exp cs=3 cin=0 a=ff b=01", alu_cs, alu_cin, alu_a, alu_b); end
    total++; if (ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL add_busy got ready=%b done=%b exp 0/0", ready, done); end
    @(negedge clk);
    total++; if ({alu_cs, alu_cin, alu_a, alu_b} !== {C_AD, 1'b1, 8'h00, 8'h00}) begin bad++; $display("FAIL add_w1 got cs=%h cin=%b a=%h b=%h exp cs=2 cin=1 a=00 b=00", alu_cs, alu_cin, alu_a, alu_b); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_early_done got=%b exp=0", done); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL add_done_lat got=%b exp=1", done); end
    total++; if ({result, carry, zero} !== {16'h0100, 1'b0, 1'b0}) begin bad++; $display("FAIL add_00ff got=%h c=%b z=%b exp=0100 c=0 z=0", result, carry, zero); end
    total++; if (alu_cs !== C_AN) begin bad++; $display("FAIL add_idle_cs got=%h exp=0", alu_cs); end
    @(negedge clk);
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL add_pulse got done=%b ready=%b exp 0/1", done, ready); end
  endtask

  task automatic test_sub_trace();
    @(negedge clk);
    op = 2'd1; opnd_a = 16'h0100; opnd_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if ({alu_cs, alu_cin} !== {C_SBX, 1'b0}) begin bad++; $display("FAIL sub_w0 got cs=%h cin=%b exp cs=5 cin=0", alu_cs, alu_cin); end
    @(negedge clk);
    total++; if ({alu_cs, alu_cin} !== {C_SB, 1'b0}) begin bad++; $display("FAIL sub_w1 got cs=%h cin=%b exp cs=4 cin=0", alu_cs, alu_cin); end
    @(negedge clk);
    total++; if ({done, result, carry, zero} !== {1'b1, 16'h00FF, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_0100 got done=%b r=%h c=%b z=%b exp 1 00ff 0 0", done, result, carry, zero); end
  endtask

  task automatic test_ops();
    logic [1:0]  t_op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] t_a  [4] = '{16'hFFFF, 16'h0000, 16'hF0F0, 16'h0000};
    logic [15:0] t_b  [4] = '{16'h0001, 16'h0001, 16'hFF00, 16'h0000};
    logic [15:0] t_r  [4] = '{16'h0000, 16'hFFFF, 16'hF000, 16'h0000};
    logic        t_c  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL ops%0d_latency got=%0d exp=3", i, lat); end
      total++; if ({result, carry, zero} !== {t_r[i], t_c[i], t_z[i]}) begin bad++; $display("FAIL ops%0d_result got=%h c=%b z=%b exp=%h c=%b z=%b", i, result, carry, zero, t_r[i], t_c[i], t_z[i]); end
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    op = 2'd0; opnd_a = 16'h0102; opnd_b = 16'h0304; start = 1'b1;
    @(negedge clk);
    op = 2'd3; opnd_a = 16'hFFFF; opnd_b = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    total++; if ({done, result} !== {1'b1, 16'h0406}) begin bad++; $display("FAIL ign_run got done=%b r=%h exp 1 0406", done, result); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ign_ready_done got=%b exp=0", ready); end
    @(negedge clk);
    start = 1'b0;
    total++; if ({ready, done, result} !== {1'b1, 1'b0, 16'h0406}) begin bad++; $display("FAIL ign_after got rdy=%b done=%b r=%h exp 1 0 0406", ready, done, result); end
    @(negedge clk);
    total++; if ({ready, result} !== {1'b1, 16'h0406}) begin bad++; $display("FAIL ign_idle got rdy=%b r=%h exp 1 0406", ready, result); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    @(negedge clk);
    op = 2'd0; opnd_a = 16'h1111; opnd_b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({ready, done, result, carry, zero} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin bad++; $display("FAIL rstmid got rdy=%b done=%b r=%h c=%b z=%b exp 1 0 0000 0 0", ready, done, result, carry, zero); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d pulses exp=0", seen); end
    do_op(2'd0, 16'h1234, 16'h0001, lat);
    total++; if ({lat, result} !== {32'd3, 16'h1235}) begin bad++; $display("FAIL rstmid_next got lat=%0d r=%h exp 3 1235", lat, result); end
  endtask

`ifdef ALU_SEQ_OVF_EN
  task automatic test_ovf();
    int lat;
    do_op(2'd0, 16'h7FFF, 16'h0001, lat);
    total++; if ({result, ovf} !== {16'h8000, 1'b1}) begin bad++; $display("FAIL ovf_add got r=%h ovf=%b exp 8000 1", result, ovf); end
    do_op(2'd1, 16'h8000, 16'h0001, lat);
    total++; if ({result, ovf} !== {16'h7FFF, 1'b1}) begin bad++; $display("FAIL ovf_sub got r=%h ovf=%b exp 7fff 1", result, ovf); end
    do_op(2'd0, 16'h0001, 16'h0001, lat);
    total++; if ({result, ovf} !== {16'h0002, 1'b0}) begin bad++; $display("FAIL ovf_none got r=%h ovf=%b exp 0002 0", result, ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_trace();
    test_sub_trace();
    test_ops();
    test_ignore_start();
    test_reset_mid();
`ifdef ALU_SEQ_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
